// File: rtl/ascii2symbol_decoder.sv
// ascii2symbol_decoder: ASCII byte stream to calculator symbol codes through a small FWFT FIFO (option: A2S_LOWERCASE_FOLD_EN)
`ifndef P_SYMBOL_CODE_WIDTH
`define P_SYMBOL_CODE_WIDTH 6
`endif
`ifndef P_SYMBOL_ZERO
`define P_SYMBOL_ZERO 0
`endif
`ifndef P_SYMBOL_A
`define P_SYMBOL_A 10
`endif
`ifndef P_SYMBOL_PLUS
`define P_SYMBOL_PLUS 36
`endif
`ifndef P_SYMBOL_MINUS
`define P_SYMBOL_MINUS 37
`endif
`ifndef P_SYMBOL_MULTIPLE
`define P_SYMBOL_MULTIPLE 38
`endif
`ifndef P_SYMBOL_SLASH
`define P_SYMBOL_SLASH 39
`endif
`ifndef P_SYMBOL_EQUAL
`define P_SYMBOL_EQUAL 40
`endif
`ifndef P_SYMBOL_COMMA
`define P_SYMBOL_COMMA 41
`endif
`ifndef P_SYMBOL_POINT
`define P_SYMBOL_POINT 42
`endif
`ifndef P_SYMBOL_SPACE
`define P_SYMBOL_SPACE 43
`endif
`ifndef P_SYMBOL_QUOTES
`define P_SYMBOL_QUOTES 44
`endif
`ifndef P_SYMBOL_ENTER
`define P_SYMBOL_ENTER 45
`endif
module ascii2symbol_decoder #(
    parameter int P_SYMBOL_WIDTH_A2S = `P_SYMBOL_CODE_WIDTH,
    parameter int P_FIFO_AW          = 2
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [7:0]                    ASCII_CODE,
    input  logic                          ASCII_VALID,
    output logic                          ASCII_READY,
    output logic [P_SYMBOL_WIDTH_A2S-1:0] SYMBOL_CODE,
    output logic                          SYMBOL_VALID,
    input  logic                          SYMBOL_READY,
    output logic                          ERROR,
    output logic [7:0]                    ERROR_CODE,
    output logic [P_FIFO_AW:0]            FIFO_COUNT
);
    localparam int DEPTH = 2 ** P_FIFO_AW;
    typedef logic [P_SYMBOL_WIDTH_A2S-1:0] sym_t;
    typedef enum logic {S_NORMAL, S_AFTER_CR} state_t;
    state_t state_q, state_d;
    logic [P_FIFO_AW:0] count_q, count_d;
    logic [P_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic err_q, err_d;
    logic [7:0] err_code_q, err_code_d;
    sym_t mem_q [DEPTH];
    sym_t sym;
    logic mapped, accept, lf_merge, push, pop;
    assign ASCII_READY  = count_q != (P_FIFO_AW+1)'(DEPTH);
    assign SYMBOL_VALID = count_q != '0;
    assign SYMBOL_CODE  = SYMBOL_VALID ? mem_q[rd_ptr_q] : '0;
    assign ERROR        = err_q;
    assign ERROR_CODE   = err_code_q;
    assign FIFO_COUNT   = count_q;
    assign accept       = ASCII_VALID && ASCII_READY;
    assign lf_merge     = state_q == S_AFTER_CR && ASCII_CODE == 8'h0A;
    assign push         = accept && mapped && !lf_merge;
    assign pop          = SYMBOL_VALID && SYMBOL_READY;
    // Combinational byte-to-symbol map; digits and letters rely on contiguous symbol codes
    always_comb begin
        sym    = '0;
        mapped = 1'b1;
        if (ASCII_CODE >= 8'h30 && ASCII_CODE <= 8'h39)
            sym = sym_t'(`P_SYMBOL_ZERO + int'(ASCII_CODE) - 'h30);
        else if (ASCII_CODE >= 8'h41 && ASCII_CODE <= 8'h5A)
            sym = sym_t'(`P_SYMBOL_A + int'(ASCII_CODE) - 'h41);
`ifdef A2S_LOWERCASE_FOLD_EN
        else if (ASCII_CODE >= 8'h61 && ASCII_CODE <= 8'h7A)
            sym = sym_t'(`P_SYMBOL_A + int'(ASCII_CODE) - 'h61);
`endif
        else begin
            case (ASCII_CODE)
                8'h2B:             sym = sym_t'(`P_SYMBOL_PLUS);
                8'h2D:             sym = sym_t'(`P_SYMBOL_MINUS);
                8'h2A:             sym = sym_t'(`P_SYMBOL_MULTIPLE);
                8'h2F:             sym = sym_t'(`P_SYMBOL_SLASH);
                8'h3D:             sym = sym_t'(`P_SYMBOL_EQUAL);
                8'h2C:             sym = sym_t'(`P_SYMBOL_COMMA);
                8'h2E:             sym = sym_t'(`P_SYMBOL_POINT);
                8'h20:             sym = sym_t'(`P_SYMBOL_SPACE);
                8'h22:             sym = sym_t'(`P_SYMBOL_QUOTES);
                8'h0D, 8'h0A, 8'h00: sym = sym_t'(`P_SYMBOL_ENTER);
                default:           mapped = 1'b0;
            endcase
        end
    end
    // Next state: CR tracking for CRLF merge, FIFO bookkeeping, error capture
    always_comb begin
        state_d    = state_q;
        if (accept)
            state_d = ASCII_CODE == 8'h0D ? S_AFTER_CR : S_NORMAL;
        count_d    = count_q + {{P_FIFO_AW{1'b0}}, push} - {{P_FIFO_AW{1'b0}}, pop};
        wr_ptr_d   = push ? wr_ptr_q + P_FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + P_FIFO_AW'(1) : rd_ptr_q;
        err_d      = accept && !mapped;
        err_code_d = err_d ? ASCII_CODE : err_code_q;
    end
    // Control state with asynchronous flush
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_NORMAL;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end
    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= sym;
    end
endmodule

// File: tb/tb_ascii2symbol_decoder.sv
// tb_ascii2symbol_decoder: directed checks of decode, FIFO flow control, CRLF merge, errors and reset
module tb_ascii2symbol_decoder;
    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] ASCII_CODE = 8'h00;
    logic       ASCII_VALID = 1'b0;
    logic       ASCII_READY;
    logic [5:0] SYMBOL_CODE;
    logic       SYMBOL_VALID;
    logic       SYMBOL_READY = 1'b0;
    logic       ERROR;
    logic [7:0] ERROR_CODE;
    logic [2:0] FIFO_COUNT;
    int n_run = 0;
    int n_fail = 0;
    localparam logic [5:0] E_ENTER = 6'd45;
    logic [7:0] t1_b [4] = '{8'h31, 8'h2B, 8'h32, 8'h3D};
    logic [5:0] t1_e [4] = '{6'd1, 6'd36, 6'd2, 6'd40};
    logic [7:0] t5_b [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30, 8'h41, 8'h42, 8'h43};
    logic [5:0] t5_e [13] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0, 6'd10, 6'd11, 6'd12};
    always #5 CLK = ~CLK;
    ascii2symbol_decoder dut (
        .CLK(CLK), .RESET_N(RESET_N), .ASCII_CODE(ASCII_CODE), .ASCII_VALID(ASCII_VALID),
        .ASCII_READY(ASCII_READY), .SYMBOL_CODE(SYMBOL_CODE), .SYMBOL_VALID(SYMBOL_VALID),
        .SYMBOL_READY(SYMBOL_READY), .ERROR(ERROR), .ERROR_CODE(ERROR_CODE), .FIFO_COUNT(FIFO_COUNT)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge CLK);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        int n = 0;
        ASCII_CODE  = b;
        ASCII_VALID = 1'b1;
        while (!ASCII_READY && n < 50) begin
            step();
            n++;
        end
        if (!ASCII_READY) check("send_timeout", 32'd0, 32'd1);
        step();
    endtask
    task automatic expect_out(input string tag, input logic [5:0] exp);
        check({tag, "_valid"}, 32'(SYMBOL_VALID), 32'd1);
        check(tag, 32'(SYMBOL_CODE), 32'(exp));
        step();
    endtask
    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(ASCII_READY), 32'd1);
        check({tag, "_valid"}, 32'(SYMBOL_VALID), 32'd0);
        check({tag, "_code"}, 32'(SYMBOL_CODE), 32'd0);
        check({tag, "_err"}, 32'(ERROR), 32'd0);
        check({tag, "_errcode"}, 32'(ERROR_CODE), 32'd0);
        check({tag, "_count"}, 32'(FIFO_COUNT), 32'd0);
    endtask
    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check_reset_values("rst");
        RESET_N = 1'b1;
        step();
        // Back-to-back arithmetic stream with the consumer always ready
        SYMBOL_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(t1_b[i]);
            check("t1_valid", 32'(SYMBOL_VALID), 32'd1);
            check("t1_code", 32'(SYMBOL_CODE), 32'(t1_e[i]));
            check("t1_err", 32'(ERROR), 32'd0);
        end
        ASCII_VALID = 1'b0;
        step();
        check("t1_empty", 32'(SYMBOL_VALID), 32'd0);
        // Fill to full, stall the fifth byte, then drain
        SYMBOL_READY = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h41 + 8'(i));
        ASCII_CODE = 8'h45;
        check("t2_full_count", 32'(FIFO_COUNT), 32'd4);
        check("t2_full_ready", 32'(ASCII_READY), 32'd0);
        step();
        check("t2_stall_count", 32'(FIFO_COUNT), 32'd4);
        check("t2_stall_ready", 32'(ASCII_READY), 32'd0);
        SYMBOL_READY = 1'b1;
        check("t2_head_a", 32'(SYMBOL_CODE), 32'd10);
        step();
        check("t2_pop_count", 32'(FIFO_COUNT), 32'd3);
        check("t2_pop_ready", 32'(ASCII_READY), 32'd1);
        check("t2_head_b", 32'(SYMBOL_CODE), 32'd11);
        step();
        ASCII_VALID = 1'b0;
        check("t2_pushpop_count", 32'(FIFO_COUNT), 32'd3);
        expect_out("t2_c", 6'd12);
        expect_out("t2_d", 6'd13);
        expect_out("t2_e", 6'd14);
        check("t2_empty", 32'(SYMBOL_VALID), 32'd0);
        // CR/LF merge and CR CR
        SYMBOL_READY = 1'b0;
        send(8'h0D);
        send(8'h0A);
        send(8'h0D);
        send(8'h0D);
        send(8'h37);
        ASCII_VALID = 1'b0;
        check("t3_count", 32'(FIFO_COUNT), 32'd4);
        SYMBOL_READY = 1'b1;
        expect_out("t3_enter0", E_ENTER);
        expect_out("t3_enter1", E_ENTER);
        expect_out("t3_enter2", E_ENTER);
        expect_out("t3_seven", 6'd7);
        check("t3_empty", 32'(SYMBOL_VALID), 32'd0);
        // Unmapped byte, then recovery
        send(8'h40);
        check("t4_err", 32'(ERROR), 32'd1);
        check("t4_errcode", 32'(ERROR_CODE), 32'h40);
        check("t4_count", 32'(FIFO_COUNT), 32'd0);
        send(8'h30);
        ASCII_VALID = 1'b0;
        check("t4_err_pulse", 32'(ERROR), 32'd0);
        check("t4_errcode_hold", 32'(ERROR_CODE), 32'h40);
        expect_out("t4_zero", 6'd0);
        // Unmapped byte after CR leaves the CR state, so a following LF pushes
        SYMBOL_READY = 1'b0;
        send(8'h0D);
        send(8'h40);
        send(8'h0A);
        ASCII_VALID = 1'b0;
        check("t4_crerr_count", 32'(FIFO_COUNT), 32'd2);
        SYMBOL_READY = 1'b1;
        expect_out("t4_cr_enter", E_ENTER);
        expect_out("t4_lf_enter", E_ENTER);
        // Simultaneous push and pop across pointer wrap
        SYMBOL_READY = 1'b0;
        for (int i = 0; i < 3; i++) send(t5_b[i]);
        SYMBOL_READY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ASCII_CODE = t5_b[3+i];
            check("t5_head", 32'(SYMBOL_CODE), 32'(t5_e[i]));
            step();
            check("t5_count", 32'(FIFO_COUNT), 32'd3);
        end
        ASCII_VALID = 1'b0;
        for (int i = 10; i < 13; i++) expect_out("t5_drain", t5_e[i]);
        check("t5_empty", 32'(SYMBOL_VALID), 32'd0);
        // Reset mid-operation after a CR with the FIFO non-empty
        SYMBOL_READY = 1'b0;
        send(8'h35);
        send(8'h0D);
        ASCII_VALID = 1'b0;
        check("t6_pre_count", 32'(FIFO_COUNT), 32'd2);
        RESET_N = 1'b0;
        #1;
        check_reset_values("t6_rst");
        step();
        RESET_N = 1'b1;
        SYMBOL_READY = 1'b1;
        send(8'h0A);
        ASCII_VALID = 1'b0;
        expect_out("t6_lf_enter", E_ENTER);
        send(8'h61);
        ASCII_VALID = 1'b0;
`ifdef A2S_LOWERCASE_FOLD_EN
        check("t6_lower_err", 32'(ERROR), 32'd0);
        expect_out("t6_lower_a", 6'd10);
`else
        check("t6_lower_err", 32'(ERROR), 32'd1);
        check("t6_lower_errcode", 32'(ERROR_CODE), 32'h61);
        check("t6_lower_count", 32'(FIFO_COUNT), 32'd0);
        step();
        check("t6_lower_pulse", 32'(ERROR), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
